// File: rtl/sysbus_pkg.sv
// Shared definitions for the system bus interconnect: FSM state encoding,
// load-type encoding carried to the slaves, and the default address map.
package sysbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } sysbus_state_e;

    typedef enum logic [2:0] {
        RT_LB  = 3'd0,
        RT_LH  = 3'd1,
        RT_LW  = 3'd2,
        RT_LBU = 3'd4,
        RT_LHU = 3'd5
    } read_type_e;

    // Four 64 KiB windows starting at 0; slave 0 sits in the LSBs.
    localparam logic [4*32-1:0] DEFAULT_BASE = {32'h0003_0000, 32'h0002_0000,
                                                32'h0001_0000, 32'h0000_0000};
    localparam logic [4*32-1:0] DEFAULT_MASK = {4{32'hFFFF_0000}};

endpackage

// File: rtl/sysbus_decoder.sv
// Combinational address decoder: reports whether the address falls in any
// slave window and which slave owns it. Overlapping windows resolve to the
// lowest slave index.
module sysbus_decoder #(
    parameter int                       NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0,
    parameter int                       IDX_W      = $clog2(NUM_SLAVES)
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest matching slave is written last.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((addr & SLAVE_MASK[k*32 +: 32]) == SLAVE_BASE[k*32 +: 32]) begin
                hit   = 1'b1;
                index = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/system_bus_interconnect.sv
// Single-master to NUM_SLAVES bus interconnect with an IDLE/ACCESS/RESP FSM.
// Optional feature: define SYSBUS_TIMEOUT_EN to abort an ACCESS that has
// waited TIMEOUT_CYC cycles without s_ready; otherwise ACCESS waits forever.
//
// Handshake: the CPU raises cpu_req and holds it (with stable address and
// data) until the one-cycle cpu_ready pulse; a slave completes its access by
// raising its s_ready bit while its s_sel bit is high, and s_ready from any
// slave that is not selected is never looked at.
module system_bus_interconnect
    import sysbus_pkg::*;
#(
    parameter int                       NUM_SLAVES  = 4,
    parameter int                       DATA_W      = 32,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE  = DEFAULT_BASE,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK  = DEFAULT_MASK,
    parameter int                       TIMEOUT_CYC = 16,
    localparam int                      IDX_W       = $clog2(NUM_SLAVES)
) (
    input  logic                         clock,
    input  logic                         reset,
    // CPU side
    input  logic                         cpu_req,
    input  logic [31:0]                  cpu_addr,
    input  logic                         cpu_write_en,
    input  logic [DATA_W-1:0]            cpu_write_data,
    input  logic [2:0]                   cpu_read_type,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic [DATA_W-1:0]            cpu_read_data,
    output logic [IDX_W-1:0]             cpu_device_id,
    // Slave side
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [31:0]                  s_addr,
    output logic                         s_write_en,
    output logic [DATA_W-1:0]            s_write_data,
    output logic [2:0]                   s_read_type,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_read_data,
    // FSM state for observation
    output logic [1:0]                   dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_ACCESS = 2'(ST_ACCESS);
    localparam logic [1:0] S_RESP   = 2'(ST_RESP);

    logic [1:0]        state;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [2:0]        rt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  dev_q;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              to_expire;

    sysbus_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .addr  (cpu_addr),
        .hit   (dec_hit),
        .index (dec_idx)
    );

    // Pick out only the latched slave's ready bit and read-data slice.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ready = s_ready[k];
                sel_rdata = s_read_data[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef SYSBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;

    assign to_expire = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count stalled ACCESS cycles; cleared whenever the FSM is not stalled.
    always_ff @(posedge clock) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == S_ACCESS && !sel_ready) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    // Transaction FSM: latch the request, wait for the slave, report back.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rt_q    <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            dev_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_write_data;
                        we_q    <= cpu_write_en;
                        rt_q    <= cpu_read_type;
                        idx_q   <= dec_idx;
                        if (dec_hit) begin
                            state <= S_ACCESS;
                            err_q <= 1'b0;
                        end else begin
                            // Miss: answer straight away, no slave is touched.
                            state   <= S_RESP;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            dev_q   <= dec_idx;
                        end
                    end
                end
                S_ACCESS: begin
                    if (sel_ready) begin
                        state   <= S_RESP;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : sel_rdata;
                        dev_q   <= idx_q;
                    end else if (to_expire) begin
                        state   <= S_RESP;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        dev_q   <= idx_q;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_sel         = (state == S_ACCESS) ? (NUM_SLAVES'(1) << idx_q) : '0;
    assign s_write_en    = (state == S_ACCESS) && we_q;
    assign s_addr        = addr_q;
    assign s_write_data  = wdata_q;
    assign s_read_type   = rt_q;
    assign cpu_ready     = (state == S_RESP);
    assign cpu_err       = (state == S_RESP) && err_q;
    assign cpu_read_data = rdata_q;
    assign cpu_device_id = dev_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_system_bus_interconnect.sv
// Directed testbench for system_bus_interconnect (default 4-slave map).
// Build with SYSBUS_TIMEOUT_EN defined to exercise the timeout path.
module tb_system_bus_interconnect;
    import sysbus_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;

    logic           clock;
    logic           reset;
    logic           cpu_req;
    logic [31:0]    cpu_addr;
    logic           cpu_write_en;
    logic [DW-1:0]  cpu_write_data;
    logic [2:0]     cpu_read_type;
    logic           cpu_ready;
    logic           cpu_err;
    logic [DW-1:0]  cpu_read_data;
    logic [1:0]     cpu_device_id;
    logic [NS-1:0]  s_sel;
    logic [31:0]    s_addr;
    logic           s_write_en;
    logic [DW-1:0]  s_write_data;
    logic [2:0]     s_read_type;
    logic [NS-1:0]  s_ready;
    logic [NS*DW-1:0] s_read_data;
    logic [1:0]     dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];

    system_bus_interconnect dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_write_en   (cpu_write_en),
        .cpu_write_data (cpu_write_data),
        .cpu_read_type  (cpu_read_type),
        .cpu_ready      (cpu_ready),
        .cpu_err        (cpu_err),
        .cpu_read_data  (cpu_read_data),
        .cpu_device_id  (cpu_device_id),
        .s_sel          (s_sel),
        .s_addr         (s_addr),
        .s_write_en     (s_write_en),
        .s_write_data   (s_write_data),
        .s_read_type    (s_read_type),
        .s_ready        (s_ready),
        .s_read_data    (s_read_data),
        .dbg_state      (dbg_state)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic we,
                             input logic [DW-1:0] wd, input logic [2:0] rt);
        cpu_addr       = a;
        cpu_write_en   = we;
        cpu_write_data = wd;
        cpu_read_type  = rt;
        cpu_req        = 1'b1;
    endtask

    task automatic set_slave(input int k, input logic [DW-1:0] d, input logic [NS-1:0] rdy);
        s_read_data[k*DW +: DW] = d;
        s_ready                 = rdy;
    endtask

    // Scoreboard comparison
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset          = 1'b0;
        cpu_req        = 1'b0;
        cpu_addr       = '0;
        cpu_write_en   = 1'b0;
        cpu_write_data = '0;
        cpu_read_type  = 3'(RT_LW);
        s_ready        = '0;
        s_read_data    = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0F00};

        // ---- Reset state ----
        repeat (3) tick();
        check("rst_state",     64'(dbg_state),     64'(ST_IDLE));
        check("rst_sel",       64'(s_sel),         64'h0);
        check("rst_we",        64'(s_write_en),    64'h0);
        check("rst_ready",     64'(cpu_ready),     64'h0);
        check("rst_err",       64'(cpu_err),       64'h0);
        check("rst_rdata",     64'(cpu_read_data), 64'h0);
        check("rst_devid",     64'(cpu_device_id), 64'h0);
        check("rst_saddr",     64'(s_addr),        64'h0);
        check("rst_swdata",    64'(s_write_data),  64'h0);
        check("rst_srtype",    64'(s_read_type),   64'h0);
        reset = 1'b1;
        tick();

        // ---- Read slave 1, ready immediately ----
        drive_req(32'h0001_0004, 1'b0, '0, 3'(RT_LW));
        tick();                                   // cycle 1: ACCESS
        check("rd1_sel",    64'(s_sel),       64'b0010);
        check("rd1_saddr",  64'(s_addr),      64'h0001_0004);
        check("rd1_rtype",  64'(s_read_type), 64'(RT_LW));
        check("rd1_we",     64'(s_write_en),  64'h0);
        check("rd1_noready",64'(cpu_ready),   64'h0);
        set_slave(1, 32'hDEAD_BEEF, 4'b0010);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();                                   // cycle 2: RESP
        check("rd1_ready",  64'(cpu_ready),     64'h1);
        check("rd1_err",    64'(cpu_err),       64'h0);
        check("rd1_devid",  64'(cpu_device_id), 64'h1);
        check("rd1_data",   64'(cpu_read_data), 64'(exp_q.pop_front()));
        check("rd1_selrsp", 64'(s_sel),         64'h0);
        s_ready = '0;
        cpu_req = 1'b0;
        tick();                                   // cycle 3: IDLE
        check("rd1_pulse",  64'(cpu_ready),     64'h0);
        check("rd1_hold",   64'(cpu_read_data), 64'hDEAD_BEEF);

        // ---- Decode miss ----
        drive_req(32'h8000_0000, 1'b0, '0, 3'(RT_LB));
        check("miss_sel0",  64'(s_sel), 64'h0);
        tick();                                   // cycle 1: RESP
        check("miss_ready", 64'(cpu_ready),     64'h1);
        check("miss_err",   64'(cpu_err),       64'h1);
        check("miss_data",  64'(cpu_read_data), 64'h0);
        check("miss_sel1",  64'(s_sel),         64'h0);
        cpu_req = 1'b0;
        tick();
        check("miss_errclr", 64'(cpu_err), 64'h0);
        check("miss_sel2",   64'(s_sel),   64'h0);

        // ---- Write slave 0 with 3 wait states, stray ready on slave 2 ----
        drive_req(32'h0000_0010, 1'b1, 32'h1234_5678, 3'(RT_LW));
        tick();                                   // cycle 1
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("wr_we_c%0d", c),    64'(s_write_en),   64'h1);
            check($sformatf("wr_sel_c%0d", c),   64'(s_sel),        64'b0001);
            check($sformatf("wr_wd_c%0d", c),    64'(s_write_data), 64'h1234_5678);
            check($sformatf("wr_nordy_c%0d", c), 64'(cpu_ready),    64'h0);
            if (c == 2)      s_ready = 4'b0100;
            else if (c == 3) s_ready = 4'b0000;
            else if (c == 4) set_slave(0, 32'hFFFF_FFFF, 4'b0001);
            tick();
        end
        exp_q.push_back(32'h0);
        check("wr_ready", 64'(cpu_ready),     64'h1);
        check("wr_err",   64'(cpu_err),       64'h0);
        check("wr_data",  64'(cpu_read_data), 64'(exp_q.pop_front()));
        check("wr_devid", 64'(cpu_device_id), 64'h0);
        check("wr_weoff", 64'(s_write_en),    64'h0);
        s_ready = '0;
        cpu_req = 1'b0;
        tick();

        // ---- Back-to-back reads: slave 0 then slave 3 ----
        drive_req(32'h0000_0020, 1'b0, '0, 3'(RT_LHU));
        tick();                                   // cycle 1: ACCESS slave 0
        check("b2b_sel0",  64'(s_sel), 64'b0001);
        set_slave(0, 32'hA5A5_0000, 4'b0001);
        tick();                                   // cycle 2: RESP
        check("b2b_rdy0",  64'(cpu_ready),     64'h1);
        check("b2b_data0", 64'(cpu_read_data), 64'hA5A5_0000);
        drive_req(32'h0003_0100, 1'b0, '0, 3'(RT_LBU));
        s_ready = 4'b0100;                        // stray pulse, slave 2
        tick();                                   // cycle 3: IDLE
        check("b2b_idle",  64'(dbg_state), 64'(ST_IDLE));
        check("b2b_gap",   64'(s_sel),     64'h0);
        tick();                                   // cycle 4: ACCESS slave 3
        check("b2b_sel3",  64'(s_sel),       64'b1000);
        check("b2b_rt3",   64'(s_read_type), 64'(RT_LBU));
        tick();                                   // cycle 5: stray ignored
        check("b2b_stray_sel", 64'(s_sel),     64'b1000);
        check("b2b_stray_rdy", 64'(cpu_ready), 64'h0);
        set_slave(3, 32'h3333_3333, 4'b1000);
        exp_q.push_back(32'h3333_3333);
        tick();                                   // cycle 6: RESP
        check("b2b_rdy3",  64'(cpu_ready),     64'h1);
        check("b2b_dev3",  64'(cpu_device_id), 64'h3);
        check("b2b_data3", 64'(cpu_read_data), 64'(exp_q.pop_front()));
        s_ready = '0;
        cpu_req = 1'b0;
        tick();

        // ---- Reset in the middle of a stalled ACCESS ----
        drive_req(32'h0002_0000, 1'b0, '0, 3'(RT_LW));
        tick();                                   // cycle 1
        check("rmid_sel1", 64'(s_sel), 64'b0100);
        tick();                                   // cycle 2
        check("rmid_sel2", 64'(s_sel), 64'b0100);
        reset = 1'b0;
        tick();                                   // cycle 3
        check("rmid_state", 64'(dbg_state),     64'(ST_IDLE));
        check("rmid_sel",   64'(s_sel),         64'h0);
        check("rmid_rdy",   64'(cpu_ready),     64'h0);
        check("rmid_rdata", 64'(cpu_read_data), 64'h0);
        reset = 1'b1;                             // req still held
        tick();                                   // ACCESS again
        check("rmid_again", 64'(s_sel), 64'b0100);
        set_slave(2, 32'h2222_2222, 4'b0100);
        tick();
        check("rmid_rdy2",  64'(cpu_ready),     64'h1);
        check("rmid_data2", 64'(cpu_read_data), 64'h2222_2222);
        check("rmid_dev2",  64'(cpu_device_id), 64'h2);
        s_ready = '0;
        cpu_req = 1'b0;
        tick();

        // ---- Slave 2 never ready ----
        drive_req(32'h0002_0040, 1'b0, '0, 3'(RT_LW));
        tick();
`ifdef SYSBUS_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("to_sel_c%0d", c), 64'(s_sel),     64'b0100);
            check($sformatf("to_rdy_c%0d", c), 64'(cpu_ready), 64'h0);
            tick();
        end
        check("to_ready", 64'(cpu_ready),     64'h1);
        check("to_err",   64'(cpu_err),       64'h1);
        check("to_data",  64'(cpu_read_data), 64'h0);
        check("to_sel",   64'(s_sel),         64'h0);
`else
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("wait_sel_c%0d", c), 64'(s_sel),     64'b0100);
            check($sformatf("wait_rdy_c%0d", c), 64'(cpu_ready), 64'h0);
            tick();
        end
        set_slave(2, 32'h5555_AAAA, 4'b0100);
        tick();
        check("wait_ready", 64'(cpu_ready),     64'h1);
        check("wait_err",   64'(cpu_err),       64'h0);
        check("wait_data",  64'(cpu_read_data), 64'h5555_AAAA);
`endif
        s_ready = '0;
        cpu_req = 1'b0;
        tick();
        check("end_idle", 64'(dbg_state), 64'(ST_IDLE));

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/system_bus_interconnect.md
SYSTEM_BUS_INTERCONNECT -- requirements
Module: system_bus_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4: number of slave ports, 2..8.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter SLAVE_BASE, default {0x0000_0000,0x0001_0000,0x0002_0000,0x0003_0000}: packed NUM_SLAVES x 32 base addresses.
REQ-004 SHALL have parameter SLAVE_MASK, default 0xFFFF_0000 per slave: packed NUM_SLAVES x 32 decode masks.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 16: maximum ACCESS cycles before a timeout error.
REQ-006 SHALL have port clock, input, 1: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-008 SHALL have CPU-side inputs: cpu_req (1), cpu_addr (32), cpu_write_en (1), cpu_write_data (DATA_W) and cpu_read_type (3).
REQ-009 SHALL have CPU-side outputs: cpu_ready (1), cpu_err (1), cpu_read_data (DATA_W) and cpu_device_id ($clog2(NUM_SLAVES)).
REQ-010 SHALL have slave-side outputs: s_sel (NUM_SLAVES), s_addr (32), s_write_en (1), s_write_data (DATA_W) and s_read_type (3).
REQ-011 SHALL have slave-side inputs: s_ready (NUM_SLAVES) and s_read_data (NUM_SLAVES x DATA_W, packed, slave 0 in the LSBs).

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-013 In IDLE with cpu_req=1, SHALL register addr, write data, write_en, read_type and the decoded index. Next state SHALL be ACCESS on a hit and RESP with error on a miss.
REQ-014 Decode SHALL hit slave k when (cpu_addr & SLAVE_MASK[k]) == SLAVE_BASE[k]; on overlap, the lowest k SHALL win.
REQ-015 In ACCESS, SHALL drive s_sel one-hot on the latched slave and drive s_addr, s_write_data, s_read_type and s_write_en from registers. s_write_en SHALL be high only in ACCESS and only for writes.
REQ-016 In ACCESS with s_ready[k]=1, SHALL capture slice k of s_read_data and go to RESP. Minimum latency: req sampled cycle 0, ready seen cycle 1, cpu_ready in cycle 2.
REQ-017 In RESP, SHALL assert cpu_ready for exactly one cycle with cpu_read_data, cpu_err and cpu_device_id valid, then go to IDLE.
REQ-018 On a decode miss or timeout, SHALL return cpu_read_data=0 and cpu_err=1; on a miss, s_sel SHALL never assert.
REQ-019 Writes SHALL complete with cpu_read_data=0 and cpu_err=0.
REQ-020 cpu_req outside IDLE SHALL be ignored; the CPU holds req until cpu_ready.
REQ-021 If cpu_req is still high in the IDLE cycle after RESP, SHALL start a new transaction (back-to-back).
REQ-022 s_ready of unselected slaves SHALL be ignored at all times.
REQ-023 Outside RESP, cpu_ready=0 and cpu_err=0; cpu_read_data and cpu_device_id SHALL hold their last values.

Reset
REQ-024 With reset=0 at a clock edge: state SHALL go to IDLE, and s_sel, s_write_en, cpu_ready and cpu_err SHALL go to 0.
REQ-025 Reset SHALL also clear cpu_read_data, cpu_device_id, s_addr, s_write_data, s_read_type and the timeout counter to 0.
REQ-026 Reset mid-ACCESS SHALL abandon the transaction: no cpu_ready, s_sel low on the next cycle.

Configuration
REQ-027 Macro SYSBUS_TIMEOUT_EN defined: an ACCESS cycle counter SHALL run, and after TIMEOUT_CYC cycles without s_ready it SHALL drop s_sel and go to RESP with cpu_err=1.
REQ-028 Macro SYSBUS_TIMEOUT_EN undefined: there SHALL be no counter, and ACCESS SHALL wait indefinitely for s_ready.

Structure
REQ-029 Package sysbus_pkg SHALL hold the FSM state enum, the read_type encoding (LB=0, LH=1, LW=2, LBU=4, LHU=5) and default base/mask constants.
REQ-030 Address decode SHALL be a combinational sub-module sysbus_decoder (addr in; hit and index out).

Verification
REQ-031 Read, slave 1 ready immediately: cpu_addr=0x0001_0004, s_ready[1]=1 in cycle 1 with data 0xDEAD_BEEF -> cpu_ready in cycle 2, cpu_read_data=0xDEAD_BEEF, cpu_device_id=1, cpu_err=0.
REQ-032 Write with 3 wait states: cpu_addr=0x0000_0010, write data 0x1234_5678, s_ready[0]=1 in cycle 4 -> s_write_en high cycles 1-4, cpu_ready in cycle 5.
REQ-033 Decode miss: cpu_addr=0x8000_0000 -> s_sel=0 throughout, cpu_ready with cpu_err=1 in cycle 1, cpu_read_data=0.
REQ-034 Timeout (SYSBUS_TIMEOUT_EN defined, TIMEOUT_CYC=16), slave 2 never ready -> s_sel[2] high for 16 cycles, then cpu_ready with cpu_err=1.
REQ-035 Back-to-back, req held high across two reads to slaves 0 then 3 -> second ACCESS starts 2 cycles after the first cpu_ready; the stray s_ready[2]=1 pulse is ignored.
REQ-036 Reset mid-op: reset=0 in cycle 2 of a stalled ACCESS -> IDLE, s_sel=0, no cpu_ready; the next request proceeds normally.
